// File: rtl/iter_divider_if.sv
// Handshake and data bundle between the execute stage and the iterative divider.
// The pipeline side is the master; the divider is the slave.
interface iter_divider_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        div_stall;
  logic [31:0] result;
  logic        result_valid;

  modport master (
    output start, funct3, op_a, op_b, flush,
    input  div_stall, result, result_valid
  );

  modport slave (
    input  start, funct3, op_a, op_b, flush,
    output div_stall, result, result_valid
  );
endinterface

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A normal op takes 32 BUSY cycles; divide-by-zero and signed overflow complete in one cycle.
module iter_divider (
  input  logic           clk,
  input  logic           rst,
  iter_divider_if.slave  dif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        sel_rem_q, sel_rem_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;

  logic        is_signed, accept, div_by_zero, overflow;
  logic [31:0] a_abs, b_abs, quo_out, rem_out;
  logic [32:0] shifted, diff;

  assign is_signed   = ~dif.funct3[0];
  assign accept      = (state_q == IDLE) && dif.start && !dif.flush;
  assign div_by_zero = (dif.op_b == 32'd0);
  assign overflow    = is_signed && (dif.op_a == 32'h8000_0000) && (dif.op_b == 32'hFFFF_FFFF);
  assign a_abs       = (is_signed && dif.op_a[31]) ? -dif.op_a : dif.op_a;
  assign b_abs       = (is_signed && dif.op_b[31]) ? -dif.op_b : dif.op_b;

  // The dividend magnitude sits in quo_q and shifts out MSB-first as quotient bits shift in.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};

  assign quo_out = neg_quo_q ? -quo_q : quo_q;
  assign rem_out = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    rem_d            = rem_q;
    quo_d            = quo_q;
    dvsr_d           = dvsr_q;
    sel_rem_d        = sel_rem_q;
    neg_quo_d        = neg_quo_q;
    neg_rem_d        = neg_rem_q;
    dif.div_stall    = 1'b0;
    dif.result_valid = 1'b0;
    dif.result       = 32'd0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dif.div_stall = 1'b1;
          sel_rem_d     = dif.funct3[1];
          cnt_d         = 5'd0;
          if (div_by_zero) begin
            quo_d     = 32'hFFFF_FFFF;
            rem_d     = dif.op_a;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DONE;
          end else if (overflow) begin
            quo_d     = 32'h8000_0000;
            rem_d     = 32'd0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DONE;
          end else begin
            quo_d     = a_abs;
            rem_d     = 32'd0;
            dvsr_d    = b_abs;
            neg_quo_d = is_signed && (dif.op_a[31] ^ dif.op_b[31]);
            neg_rem_d = is_signed && dif.op_a[31];
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        dif.div_stall = 1'b1;
        if (dif.flush) begin
          state_d = IDLE;
        end else begin
          // A borrow out of bit 32 means the divisor did not fit: restore.
          rem_d = diff[32] ? shifted[31:0] : diff[31:0];
          quo_d = {quo_q[30:0], ~diff[32]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!dif.flush) begin
          dif.result_valid = 1'b1;
          dif.result       = sel_rem_q ? rem_out : quo_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high, and state updates use non-blocking
  // assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvsr_q    <= 32'd0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed and randomized checks of iter_divider: latency, special cases, flush, reset, back-to-back.
// Expected results go into a scoreboard queue when an op is driven and are popped when result_valid rises.
module tb_iter_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  iter_divider_if dif ();

  iter_divider u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  logic [31:0] sb[$];

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference built on the simulator's own signed/unsigned arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!f3[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  // Scoreboard monitor: every valid result must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dif.result_valid === 1'b1) begin
        if (sb.size() == 0) check("unexpected_result_valid", dif.result_valid, 1'b0);
        else check("result", dif.result, sb.pop_front());
      end else begin
        check("result_zero_when_invalid", dif.result, 32'd0);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one op from an IDLE cycle and check stall/valid timing cycle by cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit special, input string tag);
    dif.start  = 1'b1;
    dif.funct3 = f3;
    dif.op_a   = a;
    dif.op_b   = b;
    sb.push_back(exp);
    #3 check({tag, "_stall_c0"}, dif.div_stall, 1'b1);
    next_cycle();
    dif.start = 1'b0;
    if (!special) begin
      for (int c = 1; c <= 32; c++) begin
        #3;
        check({tag, "_stall_busy"}, dif.div_stall, 1'b1);
        check({tag, "_valid_busy"}, dif.result_valid, 1'b0);
        next_cycle();
      end
    end
    #3;
    check({tag, "_valid_done"}, dif.result_valid, 1'b1);
    check({tag, "_stall_done"}, dif.div_stall, 1'b0);
    next_cycle();
    #3;
    check({tag, "_valid_after"}, dif.result_valid, 1'b0);
    check({tag, "_stall_after"}, dif.div_stall, 1'b0);
    next_cycle();
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bit          sp;

    // NOTE: stimulus is driven with blocking assignments 1 ns after the edge, sampled 3 ns later.
    dif.start = 1'b0; dif.flush = 1'b0; dif.funct3 = 3'b000;
    dif.op_a  = 32'd0; dif.op_b = 32'd0;
    repeat (2) next_cycle();
    rst = 1'b0;
    #3;
    check("reset_stall", dif.div_stall, 1'b0);
    check("reset_valid", dif.result_valid, 1'b0);
    check("reset_result", dif.result, 32'd0);
    mon_en = 1'b1;
    next_cycle();

    run_op(F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu_100_7");
    run_op(F_REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu_100_7");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, "rem_m7_2");
    run_op(F_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 1'b0, "div_m7_m2");
    run_op(F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, "div_5_0");
    run_op(F_REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu_5_0");
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf");
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, "rem_ovf");

    // Flush during BUSY at cycle 10: back to IDLE, no result ever.
    dif.start = 1'b1; dif.funct3 = F_DIVU; dif.op_a = 32'd1000; dif.op_b = 32'd3;
    next_cycle();
    dif.start = 1'b0;
    repeat (9) next_cycle();
    dif.flush = 1'b1;
    #3 check("flush_busy_stall_c10", dif.div_stall, 1'b1);
    next_cycle();
    dif.flush = 1'b0;
    #3;
    check("flush_busy_stall_c11", dif.div_stall, 1'b0);
    check("flush_busy_valid_c11", dif.result_valid, 1'b0);
    repeat (40) next_cycle();

    // Flush during DONE of a special case suppresses result_valid.
    dif.start = 1'b1; dif.funct3 = F_DIV; dif.op_a = 32'd5; dif.op_b = 32'd0;
    next_cycle();
    dif.start = 1'b0; dif.flush = 1'b1;
    #3 check("flush_done_valid", dif.result_valid, 1'b0);
    next_cycle();
    dif.flush = 1'b0;
    #3 check("flush_done_stall_after", dif.div_stall, 1'b0);
    next_cycle();

    // Start together with flush in IDLE is not accepted.
    dif.start = 1'b1; dif.flush = 1'b1; dif.funct3 = F_DIVU; dif.op_a = 32'd8; dif.op_b = 32'd2;
    #3 check("flush_idle_stall", dif.div_stall, 1'b0);
    next_cycle();
    dif.start = 1'b0; dif.flush = 1'b0;
    #3 check("flush_idle_stall_next", dif.div_stall, 1'b0);
    repeat (40) next_cycle();

    // Reset at cycle 20 of a BUSY op.
    dif.start = 1'b1; dif.funct3 = F_DIVU; dif.op_a = 32'd1000; dif.op_b = 32'd7;
    next_cycle();
    dif.start = 1'b0;
    repeat (19) next_cycle();
    rst = 1'b1;
    #3 check("rst_busy_stall_c20", dif.div_stall, 1'b1);
    next_cycle();
    rst = 1'b0;
    #3;
    check("rst_busy_stall", dif.div_stall, 1'b0);
    check("rst_busy_valid", dif.result_valid, 1'b0);
    check("rst_busy_result", dif.result, 32'd0);
    next_cycle();
    run_op(F_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, "divu_9_3_after_rst");

    // Start held high through DONE, then a new op in the following IDLE cycle.
    dif.start = 1'b1; dif.funct3 = F_DIVU; dif.op_a = 32'd100; dif.op_b = 32'd7;
    sb.push_back(32'd14);
    next_cycle();
    for (int c = 1; c <= 32; c++) next_cycle();
    #3;
    check("b2b_first_valid_c33", dif.result_valid, 1'b1);
    check("b2b_stall_done_start_high", dif.div_stall, 1'b0);
    next_cycle();
    dif.op_a = 32'd20; dif.op_b = 32'd4;
    sb.push_back(32'd5);
    #3 check("b2b_accept_c34", dif.div_stall, 1'b1);
    next_cycle();
    dif.start = 1'b0;
    for (int c = 35; c <= 66; c++) begin
      #3 check("b2b_valid_busy", dif.result_valid, 1'b0);
      next_cycle();
    end
    #3 check("b2b_second_valid_c67", dif.result_valid, 1'b1);
    next_cycle();
    #3 check("b2b_valid_c68", dif.result_valid, 1'b0);
    next_cycle();

    // Randomized ops against the reference model.
    for (int i = 0; i < 8; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = (i == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      sp = (b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      run_op(f3, a, b, model(f3, a, b), sp, "random");
    end

    check("scoreboard_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: start  input  1  E-stage holds a valid M-extension divide op.
REQ-004 SHALL have port: funct3  input  3  op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port: op_a  input  32  dividend (rs1 after forwarding).
REQ-006 SHALL have port: op_b  input  32  divisor (rs2 after forwarding).
REQ-007 SHALL have port: flush  input  1  abort in-flight op (control-hazard flush).
REQ-008 SHALL have port: div_stall  output  1  freeze PC, F/D and D/E registers while high.
REQ-009 SHALL have port: result  output  32  quotient or remainder per funct3.
REQ-010 SHALL have port: result_valid  output  1  result is final this cycle.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; funct3 and operands are captured at acceptance and held internally.
REQ-012 SHALL accept an op in IDLE when start=1 and flush=0 (cycle 0); no acceptance in BUSY or DONE.
REQ-013 SHALL drive div_stall combinationally: 1 when (IDLE and start and not flush) or state==BUSY; 0 in DONE.
REQ-014 SHALL, for a normal op, go IDLE->BUSY at cycle 0 edge, perform one restoring radix-2 step per cycle (32 steps, cycles 1..32, 5-bit counter 0..31), and go BUSY->DONE when counter==31.
REQ-015 SHALL assert result_valid=1 and drive result only in DONE (cycle 33 for normal op); result=0 otherwise.
REQ-016 SHALL go DONE->IDLE unconditionally after one cycle; start high during DONE SHALL NOT restart the same op.
REQ-017 SHALL, for signed ops, divide magnitudes, negate quotient when sign(op_a)!=sign(op_b), give remainder the sign of op_a.
REQ-018 SHALL use a 33-bit trial subtract of the 32-bit partial remainder; all results truncated to 32 bits.
REQ-019 SHALL handle op_b==0 as special: quotient 0xFFFFFFFF, remainder op_a, for signed and unsigned.
REQ-020 SHALL handle DIV/REM with op_a==0x80000000, op_b==0xFFFFFFFF as special: quotient 0x80000000, remainder 0.
REQ-021 SHALL send special cases IDLE->DONE directly: div_stall high cycle 0 only, result_valid cycle 1.
REQ-022 SHALL, on flush=1 in BUSY or DONE, go to IDLE next edge with result_valid=0 in that flush cycle; flush has priority over start.
REQ-023 SHALL accept a new op in the IDLE cycle immediately after DONE (back-to-back divides, one bubble-free restart).

Reset
REQ-024 SHALL on rst=1 at a clock edge enter IDLE, clear counter, partial remainder and quotient registers, regardless of state (including mid-BUSY).
REQ-025 SHALL present div_stall=0, result_valid=0, result=0 in the cycle after reset; rst has priority over flush and start.

Verification
REQ-026 DIVU op_a=100, op_b=7, start from cycle 0 -> div_stall high cycles 0..32, result_valid and result=14 at cycle 33, IDLE at 34; REMU same operands -> 2.
REQ-027 DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> result 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIV -7/-2 -> 3.
REQ-028 DIV op_a=5, op_b=0 -> div_stall high cycle 0 only, result 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, both at cycle 1.
REQ-029 DIVU 1000/3, flush at cycle 10 -> IDLE cycle 11, div_stall=0 cycle 11 (start low), result_valid never asserted.
REQ-030 rst asserted at cycle 20 of a BUSY op -> div_stall=0, result_valid=0, result=0 next cycle; subsequent DIVU 9/3 -> 3 at cycle 33.
REQ-031 start held high through DONE then new DIVU 20/4 presented in following IDLE -> exactly one result per op, second result 5 exactly 34 cycles after first.
